ctle_rx_sampler: RTL and testbench

- Downstream consumer of the CTLE model in the emulation flow.
- Once per UI, at a programmable phase, samples the CTLE's differential output (voutp − voutn, svreal fixed-point) and slices it to a bit with hysteresis.
- Deserializes the bits into words and hands each word to the checker over a valid/ready handshake.
- All timing is counted in emu_clk cycles, one cycle per DT_MSDSL step.

---
 rtl/ctle_rx_sampler.sv | 212 +++++++++++++++++++++
 tb/tb_ctle_rx_sampler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ctle_rx_sampler.sv
// Per-UI sampler and slicer for the CTLE differential output, with hysteresis,
// a word deserializer and a valid/ready handshake towards the checker.
module ctle_rx_sampler #(
  parameter int IN_WIDTH  = 18,
  parameter int UI_CYCLES = 100,
  parameter int PHASE     = 50,
  parameter int HYST      = 0,
  parameter int WORD_BITS = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                       emu_clk,
  input  logic                       emu_rst,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] voutp,
  input  logic signed [IN_WIDTH-1:0] voutn,
  input  logic                       clr_ovr,
  input  logic                       word_ready,
  output logic                       bit_out,
  output logic                       bit_valid,
  output logic [WORD_BITS-1:0]       word_out,
  output logic                       word_valid,
  output logic                       overrun,
  output logic                       busy
);

  localparam int IDX_W = (WORD_BITS > 1) ? $clog2(WORD_BITS) : 1;

  localparam logic [CNT_WIDTH-1:0] PHASE_LAST = CNT_WIDTH'(PHASE - 1);
  localparam logic [CNT_WIDTH-1:0] UI_LAST    = CNT_WIDTH'(UI_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);
  localparam logic [IDX_W-1:0]     IDX_LAST   = IDX_W'(WORD_BITS - 1);
  localparam logic [IDX_W-1:0]     IDX_ONE    = IDX_W'(1);

  // Thresholds are one bit wider than the difference so -HYST never wraps.
  localparam logic signed [IN_WIDTH+1:0] HYST_HI = (IN_WIDTH + 2)'(HYST);
  localparam logic signed [IN_WIDTH+1:0] HYST_LO = -HYST_HI;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RUN   = 2'd2
  } state_t;

  state_t               state, state_nxt;
  logic [CNT_WIDTH-1:0] cnt, cnt_nxt;
  logic                 sample;
  logic                 abort;

  logic signed [IN_WIDTH:0]   diff;
  logic signed [IN_WIDTH+1:0] diff_ext;
  logic                       decision;

  logic [IDX_W-1:0]     bit_idx, bit_idx_nxt;
  logic [WORD_BITS-1:0] shreg, shreg_nxt;
  logic [WORD_BITS-1:0] word_asm;
  logic                 word_done;

  logic [WORD_BITS-1:0] word_out_nxt;
  logic                 word_valid_nxt;
  logic                 overrun_nxt;
  logic                 drop;

  // ---------------------------------------------------------------------------
  // Phase/UI timing FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    sample    = 1'b0;
    abort     = 1'b0;
    case (state)
      IDLE: begin
        if (en) begin
          state_nxt = ALIGN;
          cnt_nxt   = '0;
        end
      end
      ALIGN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (cnt == PHASE_LAST) begin
          state_nxt = RUN;
          cnt_nxt   = '0;
          sample    = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      RUN: begin
        if (!en) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          abort     = 1'b1;
        end else if (cnt == UI_LAST) begin
          cnt_nxt = '0;
          sample  = 1'b1;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // sees pre-edge values, independent of statement order.
    if (emu_rst) begin
      state <= IDLE;
      cnt   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt != IDLE);
    end
  end

  // ---------------------------------------------------------------------------
  // Slicer: exact signed difference, hold previous decision inside the band
  // ---------------------------------------------------------------------------
  always_comb begin
    diff     = $signed({voutp[IN_WIDTH-1], voutp}) - $signed({voutn[IN_WIDTH-1], voutn});
    diff_ext = {diff[IN_WIDTH], diff};
    decision = bit_out;
    if (diff_ext > HYST_HI) begin
      decision = 1'b1;
    end else if (diff_ext < HYST_LO) begin
      decision = 1'b0;
    end
  end

  // ---------------------------------------------------------------------------
  // Deserializer: first-received bit lands in bit 0
  // ---------------------------------------------------------------------------
  always_comb begin
    bit_idx_nxt = bit_idx;
    shreg_nxt   = shreg;
    word_asm    = shreg;
    word_done   = 1'b0;
    if (abort) begin
      bit_idx_nxt = '0;
      shreg_nxt   = '0;
    end else if (sample) begin
      word_asm[bit_idx] = decision;
      if (bit_idx == IDX_LAST) begin
        word_done   = 1'b1;
        bit_idx_nxt = '0;
        shreg_nxt   = '0;
      end else begin
        bit_idx_nxt = bit_idx + IDX_ONE;
        shreg_nxt   = word_asm;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Output handshake; a completed word may replace one accepted on the same edge
  // ---------------------------------------------------------------------------
  always_comb begin
    word_out_nxt   = word_out;
    word_valid_nxt = word_valid;
    drop           = 1'b0;
    if (word_done && (!word_valid || word_ready)) begin
      word_out_nxt   = word_asm;
      word_valid_nxt = 1'b1;
    end else if (word_done) begin
      drop = 1'b1;
    end else if (word_valid && word_ready) begin
      word_valid_nxt = 1'b0;
    end

    overrun_nxt = overrun;
    if (drop) begin
      overrun_nxt = 1'b1;
    end else if (clr_ovr) begin
      overrun_nxt = 1'b0;
    end
  end

  always_ff @(posedge emu_clk or posedge emu_rst) begin
    if (emu_rst) begin
      // NOTE: the partial-word register is reset like any control state, since
      // its contents feed word_out directly.
      bit_idx    <= '0;
      shreg      <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      word_out   <= '0;
      word_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      bit_idx    <= bit_idx_nxt;
      shreg      <= shreg_nxt;
      bit_valid  <= sample;
      if (sample) begin
        bit_out <= decision;
      end
      word_out   <= word_out_nxt;
      word_valid <= word_valid_nxt;
      overrun    <= overrun_nxt;
    end
  end

endmodule

// File: tb/tb_ctle_rx_sampler.sv
// Randomized scoreboard bench for ctle_rx_sampler: an elapsed-time reference
// model queues expected bits and words, a monitor compares what the DUT shows.
module tb_ctle_rx_sampler;

  localparam int IN_WIDTH = 18;
  localparam int UI       = 100;
  localparam int PH       = 50;
  localparam int HYST     = 100;
  localparam int WB       = 8;
  localparam int IN_MAX   = (1 << (IN_WIDTH - 1)) - 1;
  localparam int IN_MIN   = -(1 << (IN_WIDTH - 1));

  logic                       emu_clk = 1'b0;
  logic                       emu_rst = 1'b1;
  logic                       en = 1'b0;
  logic signed [IN_WIDTH-1:0] voutp = '0;
  logic signed [IN_WIDTH-1:0] voutn = '0;
  logic                       clr_ovr = 1'b0;
  logic                       word_ready = 1'b0;
  logic                       bit_out, bit_valid, word_valid, overrun, busy;
  logic [WB-1:0]              word_out;

  ctle_rx_sampler #(
    .IN_WIDTH (IN_WIDTH),
    .UI_CYCLES(UI),
    .PHASE    (PH),
    .HYST     (HYST),
    .WORD_BITS(WB),
    .CNT_WIDTH(16)
  ) dut (
    .emu_clk   (emu_clk),
    .emu_rst   (emu_rst),
    .en        (en),
    .voutp     (voutp),
    .voutn     (voutn),
    .clr_ovr   (clr_ovr),
    .word_ready(word_ready),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .word_out  (word_out),
    .word_valid(word_valid),
    .overrun   (overrun),
    .busy      (busy)
  );

  always #5 emu_clk = ~emu_clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  task automatic check(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: time since enable, sample when (t - PHASE) % UI == 0
  // ---------------------------------------------------------------------------
  typedef struct {
    int cyc;
    bit val;
  } bit_exp_t;

  bit_exp_t      bit_q[$];
  logic [WB-1:0] word_q[$];
  bit            m_bits[$];
  bit            m_active = 0;
  bit            m_prev = 0;
  bit            m_pending = 0;
  bit            m_ovr = 0;
  int            m_t = 0;

  always @(posedge emu_clk or posedge emu_rst) begin : model
    bit            do_sample, complete, drop;
    int            diff;
    logic [WB-1:0] w;
    if (emu_rst) begin
      m_active = 0; m_t = 0; m_prev = 0; m_pending = 0; m_ovr = 0;
      m_bits.delete(); bit_q.delete(); word_q.delete();
    end else begin
      cyc++;
      do_sample = 0; complete = 0; drop = 0; w = '0;
      if (!m_active) begin
        if (en) begin m_active = 1; m_t = 0; end
      end else if (!en) begin
        m_active = 0;
        m_bits.delete();
      end else begin
        m_t++;
        if (m_t >= PH && (m_t - PH) % UI == 0) do_sample = 1;
      end
      if (do_sample) begin
        diff = int'(voutp) - int'(voutn);
        if (diff > HYST) m_prev = 1;
        else if (diff < -HYST) m_prev = 0;
        bit_q.push_back('{cyc, m_prev});
        m_bits.push_back(m_prev);
        if (m_bits.size() == WB) begin
          foreach (m_bits[i]) w[i] = m_bits[i];
          complete = 1;
          m_bits.delete();
        end
      end
      if (complete && (!m_pending || word_ready)) begin
        m_pending = 1;
        word_q.push_back(w);
      end else if (complete) begin
        drop = 1;
        m_ovr = 1;
      end else if (m_pending && word_ready) begin
        m_pending = 0;
      end
      if (!drop && clr_ovr) m_ovr = 0;
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: sampled on the falling edge, away from DUT updates
  // ---------------------------------------------------------------------------
  logic [3:0] prev_dut = '0;
  logic [3:0] prev_mod = '0;

  always @(negedge emu_clk) begin : monitor
    bit_exp_t   e;
    logic [3:0] dut_s, mod_s;
    if (!emu_rst) begin
      if (bit_valid) begin
        if (bit_q.size() == 0) begin
          check("bit_valid_unexpected", bit_valid, 1'b0);
        end else begin
          e = bit_q.pop_front();
          check("bit_time", cyc, e.cyc);
          check("bit_out", bit_out, e.val);
        end
      end else if (bit_q.size() > 0 && bit_q[0].cyc <= cyc) begin
        check("bit_valid_missing", bit_valid, 1'b1);
        void'(bit_q.pop_front());
      end

      if (word_valid && word_ready) begin
        if (word_q.size() == 0) check("word_unexpected", word_valid, 1'b0);
        else check("word_out", word_out, word_q.pop_front());
      end

      dut_s = {word_valid, overrun, busy, bit_out};
      mod_s = {m_pending, m_ovr, m_active, m_prev};
      if (dut_s != prev_dut || mod_s != prev_mod) check("status_vld_ovr_busy_bit", dut_s, mod_s);
      prev_dut = dut_s;
      prev_mod = mod_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic check_reset_outputs(string tag);
    check({tag, "_bit_out"}, bit_out, 1'b0);
    check({tag, "_bit_valid"}, bit_valid, 1'b0);
    check({tag, "_word_out"}, word_out, '0);
    check({tag, "_word_valid"}, word_valid, 1'b0);
    check({tag, "_overrun"}, overrun, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
  endtask

  task automatic start_run();
    @(posedge emu_clk); #2;
    en = 1'b1;
  endtask

  // One UI window; the sample falls on the (PH+1)-th rising edge of the window.
  task automatic ui_raw(int p, int n, bit pulse_ready);
    voutp = IN_WIDTH'(p);
    voutn = IN_WIDTH'(n);
    if (pulse_ready) begin
      repeat (PH) @(posedge emu_clk);
      #2 word_ready = 1'b1;
      @(posedge emu_clk);
      #2 word_ready = 1'b0;
      repeat (UI - PH - 1) @(posedge emu_clk);
      #2;
    end else begin
      repeat (UI) @(posedge emu_clk);
      #2;
    end
  endtask

  task automatic ui(int d, bit pulse_ready = 1'b0);
    ui_raw(d / 2, d / 2 - d, pulse_ready);
  endtask

  function automatic int rand_diff();
    int tbl[12] = '{500, -500, 50, -50, 100, -100, 101, -101, 0, 80, -80, 1000};
    if ($urandom_range(0, 3) == 0) return $urandom_range(0, 4000) - 2000;
    return tbl[$urandom_range(0, 11)];
  endfunction

  initial begin
    repeat (3) @(posedge emu_clk);
    #2;
    check_reset_outputs("reset");
    emu_rst = 1'b0;

    // Alternating +/-500 starting with +: word 8'h55.
    word_ready = 1'b1;
    start_run();
    for (int i = 0; i < WB; i++) ui((i % 2 == 0) ? 500 : -500);

    // Hysteresis band behaviour.
    ui(500); ui(50); ui(-50); ui(-500); ui(-80); ui(80); ui(101); ui(-101);

    // Exact-threshold and full-scale (no overflow) cases.
    ui(100); ui(101); ui(-100); ui(-101);
    ui_raw(IN_MAX, IN_MIN, 1'b0); ui_raw(IN_MIN, IN_MAX, 1'b0);
    ui(0); ui(500);

    // Two words with no consumer: second one is dropped.
    word_ready = 1'b0;
    for (int i = 0; i < 2 * WB; i++) ui(rand_diff());
    check("overrun_set", overrun, 1'b1);
    check("held_word_valid", word_valid, 1'b1);
    @(posedge emu_clk); #2 clr_ovr = 1'b1;
    @(posedge emu_clk); #2 clr_ovr = 1'b0;
    check("overrun_cleared", overrun, 1'b0);
    word_ready = 1'b1;
    @(posedge emu_clk); #2;
    check("accept_clears_valid", word_valid, 1'b0);
    en = 1'b0;
    repeat (5) @(posedge emu_clk);
    #2;

    // Completion on the same edge as acceptance of the previous word.
    word_ready = 1'b0;
    start_run();
    for (int i = 0; i < WB; i++) ui(rand_diff());
    for (int i = 0; i < WB - 1; i++) ui(rand_diff());
    ui(rand_diff(), 1'b1);
    check("coincide_valid", word_valid, 1'b1);
    check("coincide_overrun", overrun, 1'b0);

    // Five bits, then en drops on a sample edge; pending word accepted in IDLE.
    for (int i = 0; i < 5; i++) ui(rand_diff());
    voutp = IN_WIDTH'(300); voutn = IN_WIDTH'(-300);
    repeat (PH) @(posedge emu_clk);
    #2 en = 1'b0;
    repeat (10) @(posedge emu_clk);
    #2 word_ready = 1'b1;
    repeat (10) @(posedge emu_clk);
    #2;
    check("idle_accept", word_valid, 1'b0);

    // Drop en during ALIGN, then a clean word from fresh bits.
    start_run();
    repeat (20) @(posedge emu_clk);
    #2 en = 1'b0;
    repeat (5) @(posedge emu_clk);
    #2;
    start_run();
    for (int i = 0; i < WB; i++) ui(rand_diff());

    // Randomized consumer readiness.
    for (int i = 0; i < 5 * WB; i++) begin
      word_ready = ($urandom_range(0, 3) != 0);
      ui(rand_diff());
    end

    // Reset in the middle of RUN.
    word_ready = 1'b0;
    ui(500); ui(-500);
    repeat (30) @(posedge emu_clk);
    #2 emu_rst = 1'b1;
    #1 check_reset_outputs("midrun_reset");
    en = 1'b0;
    @(posedge emu_clk);
    #2 emu_rst = 1'b0;

    word_ready = 1'b1;
    start_run();
    for (int i = 0; i < WB; i++) ui(rand_diff());
    en = 1'b0;
    repeat (5) @(posedge emu_clk);
    #2;
    check("bits_outstanding", bit_q.size(), 0);
    check("words_outstanding", word_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
